// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares the data-memory port between the pipeline (P, fixed
//             priority) and an auxiliary requester (X, bounded wait), and
//             steers one-cycle-latency read data back to the read's owner.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p_rd_i,
    input  logic        p_wr_i,
    input  logic [31:0] p_addr_i,
    input  logic [31:0] p_wdata_i,
    input  logic [3:0]  p_bmask_i,
    output logic        p_stall_o,
    output logic        p_rvalid_o,
    output logic [31:0] p_rdata_o,

    input  logic        x_req_i,
    input  logic        x_we_i,
    input  logic [31:0] x_addr_i,
    input  logic [31:0] x_wdata_i,
    input  logic [3:0]  x_bmask_i,
    output logic        x_gnt_o,
    output logic        x_rvalid_o,
    output logic [31:0] x_rdata_o,

    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_bmask_o,
    input  logic [31:0] mem_rdata_i
);

    // Owner of the read that was issued in the previous cycle
    localparam logic [1:0]       c_OWN_NONE = 2'b00;
    localparam logic [1:0]       c_OWN_P    = 2'b01;
    localparam logic [1:0]       c_OWN_X    = 2'b10;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_LIMIT    = CNT_W'(STARVE_LIMIT);

    logic             w_p_req;
    logic             w_p_is_wr;
    logic             w_starved;
    logic             w_x_win;
    logic             w_p_win;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    logic [1:0]       r_rd_owner;
    logic [1:0]       w_rd_owner_nxt;
    logic             w_unused_addr_bits;

    // Byte offset is dropped: memory is word addressed
    assign w_unused_addr_bits = ^{p_addr_i[1:0], x_addr_i[1:0]};

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_p_req   = p_rd_i | p_wr_i;
        w_p_is_wr = p_wr_i;
        w_starved = (r_starve_cnt >= c_LIMIT);
        w_x_win   = ~rst & x_req_i & (~w_p_req | w_starved);
        w_p_win   = ~rst & w_p_req & ~w_x_win;
    end

    assign x_gnt_o   = w_x_win;
    assign p_stall_o = ~rst & w_p_req & w_x_win;

    // ------------------------------------------------------------------
    // Memory port drive from the winner
    // ------------------------------------------------------------------
    always_comb begin
        mem_rd_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        mem_bmask_o = 4'h0;
        if (w_x_win) begin
            mem_addr_o = {x_addr_i[31:2], 2'b00};
            if (x_we_i) begin
                mem_wdata_o = x_wdata_i;
                mem_bmask_o = x_bmask_i;
            end else begin
                mem_rd_o = 1'b1;
            end
        end else if (w_p_win) begin
            mem_addr_o = {p_addr_i[31:2], 2'b00};
            if (w_p_is_wr) begin
                mem_wdata_o = p_wdata_i;
                mem_bmask_o = p_bmask_i;
            end else begin
                mem_rd_o = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter and read-owner tracking
    // ------------------------------------------------------------------
    always_comb begin
        w_starve_nxt = '0;
        if (x_req_i && !w_x_win) begin
            w_starve_nxt = (r_starve_cnt == c_CNT_MAX) ? c_CNT_MAX
                                                       : r_starve_cnt + 1'b1;
        end

        w_rd_owner_nxt = c_OWN_NONE;
        if (w_x_win && !x_we_i) begin
            w_rd_owner_nxt = c_OWN_X;
        end else if (w_p_win && !w_p_is_wr) begin
            w_rd_owner_nxt = c_OWN_P;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_rd_owner   <= c_OWN_NONE;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_rd_owner   <= w_rd_owner_nxt;
        end
    end

    // Gated by rst so a read granted just before reset returns nothing
    assign p_rvalid_o = ~rst & (r_rd_owner == c_OWN_P);
    assign x_rvalid_o = ~rst & (r_rd_owner == c_OWN_X);
    assign p_rdata_o  = p_rvalid_o ? mem_rdata_i : 32'h0;
    assign x_rdata_o  = x_rvalid_o ? mem_rdata_i : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed and randomized checks of dmem_arbiter against a
//             behavioural model of the arbitration rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int LIMIT   = 4;
    localparam int CNT_MAX = 15;

    logic        clk;
    logic        rst;
    logic        p_rd, p_wr, p_stall, p_rvalid;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic [3:0]  p_bmask;
    logic        x_req, x_we, x_gnt, x_rvalid;
    logic [31:0] x_addr, x_wdata, x_rdata;
    logic [3:0]  x_bmask;
    logic        mem_rd;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_bmask;

    int n_vec = 0;
    int n_err = 0;

    // Model state: how long X has been waiting, and who issued last cycle's read
    int starve    = 0;
    int read_from = 0;   // 0 nobody, 1 pipeline, 2 auxiliary
    bit last_stall = 0;
    bit last_xgnt  = 0;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .p_rd_i(p_rd), .p_wr_i(p_wr), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
        .p_bmask_i(p_bmask), .p_stall_o(p_stall), .p_rvalid_o(p_rvalid),
        .p_rdata_o(p_rdata),
        .x_req_i(x_req), .x_we_i(x_we), .x_addr_i(x_addr), .x_wdata_i(x_wdata),
        .x_bmask_i(x_bmask), .x_gnt_o(x_gnt), .x_rvalid_o(x_rvalid),
        .x_rdata_o(x_rdata),
        .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_bmask_o(mem_bmask), .mem_rdata_i(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        gnt, stall, mrd, prv, xrv;
        logic [31:0] maddr, mwd, prd, xrd;
        logic [3:0]  mbm;
    } exp_t;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic bit x_wins();
        bit preq;
        preq = p_rd || p_wr;
        return !rst && x_req && (!preq || starve >= LIMIT);
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        bit xw, pw, wr;
        logic [31:0] a, d;
        logic [3:0]  m;
        e  = '0;
        xw = x_wins();
        pw = !rst && (p_rd || p_wr) && !xw;
        e.gnt   = xw;
        e.stall = (p_rd || p_wr) && xw;
        if (xw || pw) begin
            a  = xw ? x_addr  : p_addr;
            d  = xw ? x_wdata : p_wdata;
            m  = xw ? x_bmask : p_bmask;
            wr = xw ? x_we    : p_wr;
            e.maddr = {a[31:2], 2'b00};
            e.mrd   = !wr;
            e.mwd   = wr ? d : 32'h0;
            e.mbm   = wr ? m : 4'h0;
        end
        e.prv = !rst && read_from == 1;
        e.xrv = !rst && read_from == 2;
        e.prd = e.prv ? mem_rdata : 32'h0;
        e.xrd = e.xrv ? mem_rdata : 32'h0;
        return e;
    endfunction

    // Model advances on every rising edge using the inputs of the closing cycle
    always @(posedge clk) begin
        bit xw, pw;
        xw = x_wins();
        pw = !rst && (p_rd || p_wr) && !xw;
        last_stall = (p_rd || p_wr) && xw;
        last_xgnt  = xw;
        if (rst) begin
            starve    = 0;
            read_from = 0;
        end else begin
            if (x_req && !xw) starve = (starve >= CNT_MAX) ? CNT_MAX : starve + 1;
            else              starve = 0;
            if (pw && !p_wr)      read_from = 1;
            else if (xw && !x_we) read_from = 2;
            else                  read_from = 0;
        end
    end

    // Single compare process: every output, every cycle, mid-period
    always @(negedge clk) begin
        exp_t e;
        e = expect_now();
        cmp("x_gnt",     x_gnt,     e.gnt);
        cmp("p_stall",   p_stall,   e.stall);
        cmp("mem_rd",    mem_rd,    e.mrd);
        cmp("mem_addr",  mem_addr,  e.maddr);
        cmp("mem_wdata", mem_wdata, e.mwd);
        cmp("mem_bmask", mem_bmask, e.mbm);
        cmp("p_rvalid",  p_rvalid,  e.prv);
        cmp("p_rdata",   p_rdata,   e.prd);
        cmp("x_rvalid",  x_rvalid,  e.xrv);
        cmp("x_rdata",   x_rdata,   e.xrd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_all();
        p_rd = 0; p_wr = 0; p_addr = 0; p_wdata = 0; p_bmask = 0;
        x_req = 0; x_we = 0; x_addr = 0; x_wdata = 0; x_bmask = 0;
    endtask

    initial begin
        rst = 1'b1;
        mem_rdata = 32'h0;
        idle_all();

        // Reset: everything quiet even with both requesters asking
        tick();
        p_rd = 1; x_req = 1; mem_rdata = 32'h0BAD_0BAD;
        settle();
        cmp("rst_gnt", x_gnt, 1'b0);
        cmp("rst_stall", p_stall, 1'b0);
        cmp("rst_mem_rd", mem_rd, 1'b0);
        cmp("rst_p_rvalid", p_rvalid, 1'b0);

        tick();
        rst = 0; idle_all();
        settle();
        cmp("idle_mem_rd", mem_rd, 1'b0);
        cmp("idle_addr", mem_addr, 32'h0);

        // P read, byte address is word-aligned on the port
        tick();
        p_rd = 1; p_addr = 32'h0000_1006;
        settle();
        cmp("p_rd_strobe", mem_rd, 1'b1);
        cmp("p_rd_addr", mem_addr, 32'h0000_1004);
        tick();
        p_rd = 0; mem_rdata = 32'hDEAD_BEEF;
        settle();
        cmp("p_ret_valid", p_rvalid, 1'b1);
        cmp("p_ret_data", p_rdata, 32'hDEAD_BEEF);
        cmp("p_ret_xvalid", x_rvalid, 1'b0);

        // X write with P idle: granted in the same cycle
        tick();
        x_req = 1; x_we = 1; x_addr = 32'h20; x_wdata = 32'h1234_5678; x_bmask = 4'b0011;
        settle();
        cmp("x_wr_gnt", x_gnt, 1'b1);
        cmp("x_wr_bmask", mem_bmask, 4'b0011);
        cmp("x_wr_rd", mem_rd, 1'b0);
        cmp("x_wr_data", mem_wdata, 32'h1234_5678);

        // Starvation: P holds the port for LIMIT cycles, then X gets a slot
        tick();
        x_we = 0; x_addr = 32'h44; x_bmask = 0; x_wdata = 0;
        p_rd = 1; p_addr = 32'h100;
        for (int i = 1; i <= LIMIT; i++) begin
            settle();
            cmp("starve_wait_gnt", x_gnt, 1'b0);
            cmp("starve_wait_stall", p_stall, 1'b0);
            cmp("starve_wait_addr", mem_addr, 32'h100);
            tick();
        end
        settle();
        cmp("forced_gnt", x_gnt, 1'b1);
        cmp("forced_stall", p_stall, 1'b1);
        cmp("forced_addr", mem_addr, 32'h44);
        tick();
        settle();
        cmp("after_force_gnt", x_gnt, 1'b0);
        cmp("after_force_stall", p_stall, 1'b0);
        cmp("after_force_addr", mem_addr, 32'h100);
        cmp("after_force_xrv", x_rvalid, 1'b1);

        // Alternating reads: returns go to the right owner, never both
        tick();
        idle_all();
        p_rd = 1; p_addr = 32'h200;
        settle();
        tick();
        p_rd = 0; x_req = 1; x_addr = 32'h300; mem_rdata = 32'hAAAA_5555;
        settle();
        cmp("alt_p_rvalid", p_rvalid, 1'b1);
        cmp("alt_p_rdata", p_rdata, 32'hAAAA_5555);
        cmp("alt_x_idle", x_rvalid, 1'b0);
        tick();
        x_req = 0; mem_rdata = 32'h5555_AAAA;
        settle();
        cmp("alt_x_rvalid", x_rvalid, 1'b1);
        cmp("alt_x_rdata", x_rdata, 32'h5555_AAAA);
        cmp("alt_p_idle", p_rvalid, 1'b0);

        // Reset right after a read grant drops the return
        tick();
        p_rd = 1; p_addr = 32'h400;
        settle();
        cmp("pre_rst_rd", mem_rd, 1'b1);
        tick();
        p_rd = 0; rst = 1; x_req = 1; mem_rdata = 32'h1111_1111;
        settle();
        cmp("rst_drop_rvalid", p_rvalid, 1'b0);
        cmp("rst_drop_rdata", p_rdata, 32'h0);
        cmp("rst_drop_gnt", x_gnt, 1'b0);
        tick();
        rst = 0; x_req = 0;
        settle();
        cmp("post_rst_rvalid", p_rvalid, 1'b0);

        // Read and write together means write
        tick();
        p_rd = 1; p_wr = 1; p_bmask = 4'hF; p_wdata = 32'hCAFE_F00D; p_addr = 32'h503;
        settle();
        cmp("both_rd", mem_rd, 1'b0);
        cmp("both_bmask", mem_bmask, 4'hF);
        cmp("both_addr", mem_addr, 32'h500);
        tick();
        idle_all();
        settle();
        cmp("both_no_rvalid", p_rvalid, 1'b0);

        // Randomized traffic obeying both handshakes
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst       = ($urandom_range(0, 99) == 0);
            mem_rdata = $urandom;
            if (!(last_stall && (p_rd || p_wr))) begin
                case ($urandom_range(0, 5))
                    0, 1:    begin p_rd = 0; p_wr = 0; end
                    2, 3:    begin p_rd = 1; p_wr = 0; end
                    4:       begin p_rd = 0; p_wr = 1; end
                    default: begin p_rd = 1; p_wr = 1; end
                endcase
                p_addr = $urandom; p_wdata = $urandom; p_bmask = 4'($urandom);
            end
            if (!(x_req && !last_xgnt)) begin
                x_req = ($urandom_range(0, 2) != 0);
                x_we  = $urandom_range(0, 1) == 1;
                x_addr = $urandom; x_wdata = $urandom; x_bmask = 4'($urandom);
            end
        end

        tick();
        idle_all();
        rst = 0;
        settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
